// File: rtl/oled_line_drawer_pkg.sv
// oled_pkg: shared constants and types for the SSD1306 line drawer.
//   - Panel geometry (OLED_W x OLED_H) and the coordinate widths it implies.
//   - Encodings of the display driver's pixel_state bus.
//   - Error-term widths used by the Bresenham datapath.
//   - line_state_t: the line drawer FSM states, exported for debug.
package oled_pkg;

  localparam int OLED_W   = 128;
  localparam int OLED_H   = 64;
  localparam int OLED_X_W = $clog2(OLED_W);
  localparam int OLED_Y_W = $clog2(OLED_H);

  // Signed error term and its doubled form; wide enough for |dx|<=127, |dy|<=63.
  localparam int ERR_W = 10;
  localparam int E2_W  = ERR_W + 1;

  localparam logic [1:0] PIX_IDLE  = 2'd0;
  localparam logic [1:0] PIX_READ  = 2'd1;
  localparam logic [1:0] PIX_WRITE = 2'd2;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_SETUP,
    LD_ISSUE,
    LD_ACK,
    LD_BUSYWAIT,
    LD_FIN
  } line_state_t;

endpackage

// File: rtl/oled_line_drawer_if.sv
// oled_line_if: bundles the line drawer's command side and pixel side.
//   Command side : start, x0, y0, x1, y1, color -> drawer; start_ready, busy, done <- drawer.
//   Pixel side   : pixel_state -> drawer; pixel, x, y, pixel_we <- drawer.
// Handshake: a command transfers on any cycle where start && start_ready are both
// high; start may be held or dropped freely while start_ready is low, and the
// command fields are only meaningful in the transfer cycle.
// Modports: master = the line drawer, slave = the command source plus driver.
interface oled_line_if #(
  parameter int X_W = 7,
  parameter int Y_W = 6
);
  logic           start;
  logic [X_W-1:0] x0;
  logic [X_W-1:0] x1;
  logic [Y_W-1:0] y0;
  logic [Y_W-1:0] y1;
  logic           color;
  logic           start_ready;
  logic           busy;
  logic           done;
  logic [1:0]     pixel_state;
  logic           pixel;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           pixel_we;

  modport master (
    input  start, x0, x1, y0, y1, color, pixel_state,
    output start_ready, busy, done, pixel, x, y, pixel_we
  );

  modport slave (
    output start, x0, x1, y0, y1, color, pixel_state,
    input  start_ready, busy, done, pixel, x, y, pixel_we
  );
endinterface

// File: rtl/oled_line_drawer_cmd_slot.sv
// oled_line_cmd_slot: holds the command of the line being drawn ("active") and,
// when OLED_LINE_QUEUE_EN is defined, one pending command behind it.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream command handshake (in_ready is start_ready)
//   in_data         : packed command {color, x0, y0, x1, y1}
//   busy            : drawer is mid-line
//   next_valid      : a command is available for the drawer to take
//   take            : drawer loads the next command into the active register
//   active          : command currently being drawn
// Macro OLED_LINE_QUEUE_EN: adds the pending entry; otherwise commands are only
// accepted while idle and pass straight into the active register.
module oled_line_cmd_slot #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         busy,
  output logic         next_valid,
  input  logic         take,
  output logic [W-1:0] active
);

  logic [W-1:0] next_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else if (take) begin
      active <= next_data;
    end
  end

`ifdef OLED_LINE_QUEUE_EN
  logic         pend_valid;
  logic [W-1:0] pend_data;

  assign in_ready   = !pend_valid;
  // The pending entry always has priority; a fresh command only bypasses it
  // when the drawer is idle and nothing is waiting.
  assign next_valid = pend_valid || (in_valid && !busy);
  assign next_data  = pend_valid ? pend_data : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (take && pend_valid) begin
      pend_valid <= 1'b0;
    end else if (in_valid && in_ready && busy) begin
      pend_valid <= 1'b1;
      pend_data  <= in_data;
    end
  end
`else
  assign in_ready   = !busy;
  assign next_valid = in_valid && !busy;
  assign next_data  = in_data;
`endif

endmodule

// File: rtl/oled_line_drawer.sv
// oled_line_drawer: rasterises line commands with integer Bresenham and issues
// one pixel write per point to the SSD1306 driver, paced by its pixel_state
// read-modify-write sequence (IDLE -> READ -> WRITE -> IDLE).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : oled_line_if.master (command handshake + pixel write interface)
//   state_dbg : current FSM state
// Macro OLED_LINE_QUEUE_EN (in oled_line_cmd_slot): one-deep command queue.
module oled_line_drawer
  import oled_pkg::*;
#(
  parameter int X_W = OLED_X_W,
  parameter int Y_W = OLED_Y_W
) (
  input  logic        clk,
  input  logic        rst,
  oled_line_if.master bus,
  output line_state_t state_dbg
);

  localparam int CMD_W = 2 * X_W + 2 * Y_W + 1;

  line_state_t state;

  logic             cmd_valid;
  logic             cmd_take;
  logic [CMD_W-1:0] cmd_active;
  logic             c_color;
  logic [X_W-1:0]   c_x0, c_x1;
  logic [Y_W-1:0]   c_y0, c_y1;

  oled_line_cmd_slot #(.W(CMD_W)) u_slot (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.start),
    .in_ready   (bus.start_ready),
    .in_data    ({bus.color, bus.x0, bus.y0, bus.x1, bus.y1}),
    .busy       (state != LD_IDLE),
    .next_valid (cmd_valid),
    .take       (cmd_take),
    .active     (cmd_active)
  );

  assign {c_color, c_x0, c_y0, c_x1, c_y1} = cmd_active;
  assign cmd_take = cmd_valid && ((state == LD_IDLE) || (state == LD_FIN));

  // Bresenham state: cursor, signed deltas (dy stored negative), error, directions.
  logic [X_W-1:0]          cx;
  logic [Y_W-1:0]          cy;
  logic signed [ERR_W-1:0] dx, dy, err;
  logic                    sx_neg, sy_neg;

  logic [X_W-1:0]          adx;
  logic [Y_W-1:0]          ady;
  logic signed [ERR_W-1:0] setup_dx, setup_dy;
  logic signed [E2_W-1:0]  e2, dx_w, dy_w;
  logic                    step_x, step_y, at_end;
  logic signed [ERR_W-1:0] err_next;
  logic [X_W-1:0]          cx_next;
  logic [Y_W-1:0]          cy_next;

  always_comb begin
    adx      = (c_x1 >= c_x0) ? (c_x1 - c_x0) : (c_x0 - c_x1);
    ady      = (c_y1 >= c_y0) ? (c_y1 - c_y0) : (c_y0 - c_y1);
    setup_dx = ERR_W'(adx);
    setup_dy = -ERR_W'(ady);

    e2   = {err, 1'b0};
    dx_w = {dx[ERR_W-1], dx};
    dy_w = {dy[ERR_W-1], dy};
    // Both decisions look at the error before this step's update.
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);

    err_next = err;
    if (step_x) err_next = err_next + dy;
    if (step_y) err_next = err_next + dx;

    cx_next = cx;
    if (step_x) cx_next = sx_neg ? (cx - X_W'(1)) : (cx + X_W'(1));
    cy_next = cy;
    if (step_y) cy_next = sy_neg ? (cy - Y_W'(1)) : (cy + Y_W'(1));

    at_end = (cx == c_x1) && (cy == c_y1);
  end

  // The Bresenham step is taken on the same edge that leaves BUSYWAIT, so the
  // cursor only moves once the driver is back in IDLE (it re-reads x/y/pixel in
  // WRITE) and the next write can issue the following cycle: 4-cycle period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LD_IDLE;
      cx     <= '0;
      cy     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: if (cmd_valid) state <= LD_SETUP;
        LD_SETUP: begin
          dx     <= setup_dx;
          dy     <= setup_dy;
          err    <= setup_dx + setup_dy;
          sx_neg <= (c_x1 < c_x0);
          sy_neg <= (c_y1 < c_y0);
          cx     <= c_x0;
          cy     <= c_y0;
          state  <= LD_ISSUE;
        end
        LD_ISSUE: if (bus.pixel_state == PIX_IDLE) state <= LD_ACK;
        LD_ACK: if (bus.pixel_state != PIX_IDLE) state <= LD_BUSYWAIT;
        LD_BUSYWAIT: begin
          if (bus.pixel_state == PIX_IDLE) begin
            if (at_end) begin
              state <= LD_FIN;
            end else begin
              err   <= err_next;
              cx    <= cx_next;
              cy    <= cy_next;
              state <= LD_ISSUE;
            end
          end
        end
        LD_FIN: state <= cmd_valid ? LD_SETUP : LD_IDLE;
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != LD_IDLE);
  assign bus.done     = (state == LD_FIN);
  assign bus.pixel_we = (state == LD_ISSUE) && (bus.pixel_state == PIX_IDLE);
  assign bus.x        = cx;
  assign bus.y        = cy;
  assign bus.pixel    = c_color;
  assign state_dbg    = state;

endmodule

// File: tb/tb_oled_line_drawer.sv
// Testbench for oled_line_drawer: driver model for pixel_state, software
// Bresenham scoreboard, table of lines, plus stall / reset / busy-start sequences.
module tb_oled_line_drawer;
  import oled_pkg::*;

  localparam int X_W = 7;
  localparam int Y_W = 6;
  localparam int PW  = X_W + Y_W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  line_state_t state_dbg;

  oled_line_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  oled_line_drawer #(.X_W(X_W), .Y_W(Y_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

  logic [PW-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver model ----------------
  logic [1:0] drv_ps     = PIX_IDLE;
  int         stall_at   = 0;
  int         stall_len  = 0;
  int         stall_left = 0;

  assign bus.pixel_state = drv_ps;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    case (drv_ps)
      PIX_IDLE: if (bus.pixel_we) begin
        drv_ps     <= PIX_READ;
        stall_left <= (stall_at != 0 && we_cnt == stall_at) ? stall_len : 0;
      end
      PIX_READ: begin
        if (stall_left > 0) stall_left <= stall_left - 1;
        else drv_ps <= PIX_WRITE;
      end
      default: drv_ps <= PIX_IDLE;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  logic           prev_we = 1'b0;
  logic           hold_on = 1'b0;
  logic           hold_en = 1'b1;
  logic [X_W-1:0] hold_x;
  logic [Y_W-1:0] hold_y;
  logic           hold_p;

  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (bus.pixel_we) begin
      we_cnt++;
      chk("we_back_to_back", int'(prev_we), 0);
      chk("we_driver_idle", int'(bus.pixel_state), int'(PIX_IDLE));
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pix_value", int'(bus.pixel), int'(e[PW-1]));
        chk("pix_x", int'(bus.x), int'(e[Y_W +: X_W]));
        chk("pix_y", int'(bus.y), int'(e[Y_W-1:0]));
      end
      hold_x  = bus.x;
      hold_y  = bus.y;
      hold_p  = bus.pixel;
      hold_on = 1'b1;
    end else if (hold_on && hold_en) begin
      if (bus.pixel_state == PIX_IDLE) begin
        hold_on = 1'b0;
      end else begin
        chk("hold_x", int'(bus.x), int'(hold_x));
        chk("hold_y", int'(bus.y), int'(hold_y));
        chk("hold_pixel", int'(bus.pixel), int'(hold_p));
      end
    end
    if (!hold_en) hold_on = 1'b0;
    if (bus.done) done_cnt++;
    prev_we = bus.pixel_we;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                           input bit c, output int n);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    n   = 0;
    while (n < 400) begin
      exp_q.push_back({c, X_W'(x), Y_W'(y)});
      n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1, input bit c);
    bus.x0    = X_W'(x0);
    bus.y0    = Y_W'(y0);
    bus.x1    = X_W'(x1);
    bus.y1    = Y_W'(y1);
    bus.color = c;
  endtask

  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                          input bit c, output int acc);
    @(negedge clk);
    set_cmd(x0, y0, x1, y1, c);
    bus.start = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.start_ready && !bus.busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, input int budget, output int dcyc);
    bit ok = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; dcyc = cyc; break; end
    end
    if (!ok) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_line(input string name, input int x0, input int y0, input int x1,
                          input int y1, input bit c, input int exp_n, input int extra);
    int n, acc, dcyc, we0, d0;
    wait_ready(name);
    push_line(x0, y0, x1, y1, c, n);
    chk({name, "_model_len"}, n, exp_n);
    we0 = we_cnt;
    d0  = done_cnt;
    send_cmd(x0, y0, x1, y1, c, acc);
    wait_done(name, 4 * exp_n + extra + 40, dcyc);
    chk({name, "_writes"}, we_cnt - we0, exp_n);
    chk({name, "_done_latency"}, dcyc - acc, 4 * exp_n + 2 + extra);
    chk({name, "_sb_left"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_idle_after"}, int'(bus.busy), 0);
    exp_q.delete();
  endtask

  typedef struct {
    string name;
    int    x0, y0, x1, y1;
    bit    color;
    int    n;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, dcyc, we0, d0, seen, wcyc, n;
    bit ok;

    vecs[0] = '{"point",       5,  5,   5,  5, 1'b1, 1};
    vecs[1] = '{"horizontal",  0, 10, 127, 10, 1'b1, 128};
    vecs[2] = '{"steep_rev",  20, 63,  17,  0, 1'b0, 64};
    vecs[3] = '{"diagonal",    0,  0,  10, 10, 1'b1, 11};
    vecs[4] = '{"shallow",     3,  2,  40,  9, 1'b1, 38};
    vecs[5] = '{"reverse",   100, 50,  60, 20, 1'b0, 41};
    vecs[6] = '{"vertical",   64,  0,  64, 63, 1'b1, 64};
    vecs[7] = '{"full_diag", 127, 63,   0,  0, 1'b1, 128};

    bus.start = 1'b0;
    set_cmd(0, 0, 0, 0, 1'b0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start_ready", int'(bus.start_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pixel_we", int'(bus.pixel_we), 0);
    chk("rst_pixel", int'(bus.pixel), 0);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_state", int'(state_dbg), int'(LD_IDLE));
    rst = 1'b0;

    // table-driven lines
    for (int i = 0; i < 8; i++)
      run_line(vecs[i].name, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
               vecs[i].color, vecs[i].n, 0);

    // driver stalls 10 extra cycles in READ on the 3rd pixel
    stall_at  = we_cnt + 3;
    stall_len = 10;
    run_line("stall", 0, 0, 6, 3, 1'b1, 7, 10);
    stall_at  = 0;

    // reset during the 2nd pixel of (0,0)->(10,10)
    wait_ready("rst_mid");
    push_line(0, 0, 10, 10, 1'b1, n);
    send_cmd(0, 0, 10, 10, 1'b1, acc);
    seen = 0;
    ok   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.pixel_we) seen++;
      if (seen == 2) begin ok = 1'b1; break; end
    end
    chk("rst_mid_second_we_seen", int'(ok), 1);
    hold_en = 1'b0;
    rst     = 1'b1;
    d0      = done_cnt;
    @(negedge clk);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_pixel_we", int'(bus.pixel_we), 0);
    chk("rst_mid_state", int'(state_dbg), int'(LD_IDLE));
    chk("rst_mid_done", int'(bus.done), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_idle", int'(bus.busy), 0);
    hold_en = 1'b1;
    run_line("after_rst", 0, 0, 10, 10, 1'b1, 11, 0);

`ifdef OLED_LINE_QUEUE_EN
    // second command queued behind the first, third refused while slot is full
    wait_ready("queue");
    push_line(0, 0, 3, 0, 1'b1, n);
    push_line(10, 10, 12, 12, 1'b0, n);
    we0 = we_cnt;
    send_cmd(0, 0, 3, 0, 1'b1, acc);
    @(negedge clk);
    chk("queue_ready_busy_empty", int'(bus.start_ready), 1);
    send_cmd(10, 10, 12, 12, 1'b0, dcyc);
    @(negedge clk);
    chk("queue_ready_full", int'(bus.start_ready), 0);
    set_cmd(50, 50, 50, 50, 1'b1);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done("queue_first", 60, dcyc);
    chk("queue_first_latency", dcyc - acc, 18);
    wcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.pixel_we) begin wcyc = cyc; break; end
    end
    chk("queue_second_first_we", wcyc - dcyc, 2);
    acc = dcyc;
    wait_done("queue_second", 60, dcyc);
    chk("queue_second_latency", dcyc - acc, 14);
    repeat (20) @(negedge clk);
    chk("queue_total_writes", we_cnt - we0, 7);
    chk("queue_sb_left", exp_q.size(), 0);
    chk("queue_idle", int'(bus.busy), 0);
    chk("queue_ready_after", int'(bus.start_ready), 1);
    exp_q.delete();
`else
    // start while busy is ignored
    wait_ready("busy_start");
    push_line(0, 0, 3, 0, 1'b1, n);
    we0 = we_cnt;
    d0  = done_cnt;
    send_cmd(0, 0, 3, 0, 1'b1, acc);
    repeat (2) @(negedge clk);
    chk("busy_start_ready", int'(bus.start_ready), 0);
    set_cmd(30, 30, 31, 31, 1'b0);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start", 60, dcyc);
    chk("busy_start_latency", dcyc - acc, 18);
    repeat (20) @(negedge clk);
    chk("busy_start_writes", we_cnt - we0, 4);
    chk("busy_start_done_cnt", done_cnt - d0, 1);
    chk("busy_start_idle", int'(bus.busy), 0);
    chk("busy_start_sb_left", exp_q.size(), 0);
    exp_q.delete();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
